// File: rtl/reg_ro_bank_if.sv
// Sir register bus: select/read/address towards the slave, registered ack/data back.
interface reg_ro_bank_if #(
  parameter int ADDRWIDTH = 8,
  parameter int DATAWIDTH = 32
);
  logic                 SirSel;
  logic                 SirRead;
  logic [ADDRWIDTH-1:0] SirAddr;
  logic                 SirDack;
  logic [DATAWIDTH-1:0] SirRdat;

  modport master (output SirSel, SirRead, SirAddr, input SirDack, SirRdat);
  modport slave  (input SirSel, SirRead, SirAddr, output SirDack, SirRdat);
endinterface

// File: rtl/reg_ro_bank.sv
// Bank of read-only status channels plus an update bitmap on the Sir bus.
// Each channel either holds its last loaded value or accumulates (OR) until read.
module reg_ro_bank #(
  parameter int                       ADDRWIDTH = 8,
  parameter int                       DATAWIDTH = 32,
  parameter int                       NUM_REGS  = 4,
  parameter logic [ADDRWIDTH-1:0]     BASEADDR  = 8'h10,
  parameter logic [DATAWIDTH-1:0]     INITVALUE = '0,
  parameter logic [NUM_REGS-1:0]      COR_MASK  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  reg_ro_bank_if.slave                  sir,
  input  logic [NUM_REGS-1:0]           Load,
  input  logic [NUM_REGS*DATAWIDTH-1:0] D,
  output logic [NUM_REGS-1:0]           Upd
);

  // One extra address bit so BASEADDR+NUM_REGS cannot wrap.
  localparam logic [ADDRWIDTH:0] ADDR_LO = {1'b0, BASEADDR};
  localparam logic [ADDRWIDTH:0] ADDR_HI = ADDR_LO + (ADDRWIDTH+1)'(NUM_REGS);

  logic [DATAWIDTH-1:0] q [NUM_REGS];
  logic [NUM_REGS-1:0]  upd_q;
  logic                 dack_q;
  logic [DATAWIDTH-1:0] rdat_q;

  logic                 hit;
  logic                 rd;
  logic [ADDRWIDTH-1:0] idx;
  logic [NUM_REGS-1:0]  rd_ch;
  logic                 rd_map;
  logic [DATAWIDTH-1:0] rdat_nxt;

  always_comb begin
    hit    = sir.SirSel && ({1'b0, sir.SirAddr} >= ADDR_LO) && ({1'b0, sir.SirAddr} <= ADDR_HI);
    rd     = hit && sir.SirRead;
    idx    = sir.SirAddr - BASEADDR;
    rd_map = rd && (idx == ADDRWIDTH'(NUM_REGS));
    rd_ch  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_ch[i] = rd && (idx == ADDRWIDTH'(i));
    end
  end

  always_comb begin
    rdat_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_ch[i]) rdat_nxt = q[i];
    end
    if (rd_map) rdat_nxt[NUM_REGS-1:0] = upd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dack_q <= 1'b0;
      rdat_q <= '0;
      upd_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) q[i] <= INITVALUE;
    end else begin
      dack_q <= hit;
      rdat_q <= rdat_nxt;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (COR_MASK[i]) begin
          // A load coinciding with the clearing read survives into the next value.
          if (rd_ch[i] && Load[i])  q[i] <= INITVALUE | D[i*DATAWIDTH +: DATAWIDTH];
          else if (rd_ch[i])        q[i] <= INITVALUE;
          else if (Load[i])         q[i] <= q[i] | D[i*DATAWIDTH +: DATAWIDTH];
        end else if (Load[i]) begin
          q[i] <= D[i*DATAWIDTH +: DATAWIDTH];
        end
        if (Load[i])       upd_q[i] <= 1'b1;
        else if (rd_ch[i]) upd_q[i] <= 1'b0;
      end
    end
  end

  assign sir.SirDack = dack_q;
  assign sir.SirRdat = rdat_q;
  assign Upd         = upd_q;

endmodule

// File: doc/reg_ro_bank.md
# reg_ro_bank

Parametrised bank of read-only status registers on the Sir register bus. It replaces per-register read-only instances with one block that serves `NUM_REGS` consecutive addresses plus an update-bitmap register. Each channel works in one of two modes, selected per channel at elaboration:
- hold-last-value;
- sticky-OR, cleared when read.

It sits between datapath status sources and the Sir bus read mux. Its registered `SirDack`/`SirRdat` are ORed with other slaves.

## Interface
Parameters:
- `ADDRWIDTH`, 8, Sir address width.
- `DATAWIDTH`, 32, register width; must be ≥ `NUM_REGS`.
- `NUM_REGS`, 4, channel count, 1..32.
- `BASEADDR`, 8'h10, address of channel 0; channel i at `BASEADDR+i`; bitmap at `BASEADDR+NUM_REGS`.
- `INITVALUE`, 0, reset value of every channel register.
- `COR_MASK`, {NUM_REGS{1'b0}}, bit i=1 puts channel i in sticky clear-on-read mode.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset rst, synchronous, active-high.
- `SirSel`  in  1  bus select.
- `SirRead`  in  1  1 = read access, 0 = write access (ignored).
- `SirAddr`  in  ADDRWIDTH  access address.
- `SirDack`  out  1  registered acknowledge.
- `SirRdat`  out  DATAWIDTH  registered read data, zero when not reading this block.
- `Load`  in  NUM_REGS  per-channel update strobe.
- `D`  in  NUM_REGS*DATAWIDTH  packed channel data; channel i = `D[i*DATAWIDTH +: DATAWIDTH]`.
- `Upd`  out  NUM_REGS  live update bitmap; bit i set = channel i loaded since its last read.

## Operation
- Address decode:
  - hit = `SirSel` & (`BASEADDR` ≤ `SirAddr` ≤ `BASEADDR+NUM_REGS`).
  - idx = `SirAddr-BASEADDR`.
  - rd = hit & `SirRead`.
- Channel i, hold mode (`COR_MASK[i]`=0):
  - `Load[i]` → Q[i] <= D_i; otherwise Q[i] holds.
  - A read does not modify Q[i].
- Channel i, sticky mode (`COR_MASK[i]`=1):
  - `Load[i]` → Q[i] <= Q[i] | D_i.
  - rd to idx=i → Q[i] <= `INITVALUE`.
  - Load and read to the same channel in the same cycle → Q[i] <= `INITVALUE` | D_i. The new event is never lost.
- Update bitmap U:
  - `Load[i]` sets U[i].
  - rd to idx=i clears U[i].
  - Simultaneous Load and read of channel i → U[i] stays 1.
  - A read of the bitmap address does not change U.
- Read data:
  - rd to a channel returns that channel's pre-edge Q.
  - rd to the bitmap returns {zeros, U} (pre-edge value).
  - Any other cycle → `SirRdat` = 0.
- Write access (hit & !`SirRead`) → `SirDack`=1, `SirRdat`=0, no state change.
- Out-of-range address or `SirSel`=0 → no `SirDack`, no state change.
- `Upd` = U, driven directly from the register.

## Timing
- All outputs registered; reset values:
  - `SirDack`=0, `SirRdat`=0, `Upd`=0.
  - All Q = `INITVALUE`.
- Latency: access presented in cycle n → `SirDack`/`SirRdat` valid in cycle n+1 for exactly one cycle per accepted access cycle.
- Back-to-back accesses are accepted every cycle. There are no wait states and no stall.
- Clear-on-read and U clear take effect at the same edge that captures `SirRdat`. A read in cycle n+1 sees the cleared value.
- `Load` in cycle n is visible to a read issued in cycle n+1, not to a read issued in cycle n.
- `rst` dominates every other input, including a Load or read in the same cycle. An access in the reset cycle produces no `SirDack` in the following cycle.

## Test plan
- Reset then idle: `Upd`=0, `SirDack`=0, `SirRdat`=0. Reads of `BASEADDR`+0..3 return 0; read of `BASEADDR+4` returns 0.
- Hold channel 0: `Load[0]` with D=32'hDEAD_BEEF, then read 8'h10 twice. Both reads return DEADBEEF with `SirDack` one cycle after select. `Upd[0]` goes 1→0 after the first read.
- Sticky channel 1 (`COR_MASK`=4'b0010):
  - Load 32'h1, then Load 32'h4, then read 8'h11 → 32'h5.
  - Next read of 8'h11 → 0.
- Race on channel 1: read 8'h11 with simultaneous `Load[1]`, D=32'h8, while Q=32'h3. Read returns 32'h3; next read returns 32'h8; `Upd[1]` stays 1 through the first read.
- Bitmap register:
  - Load channels 0 and 2, read 8'h14 → 32'h5, `Upd` unchanged.
  - Write to 8'h12 → `SirDack`=1, `SirRdat`=0, `Upd`=4'b0101.
- Out-of-range and reset:
  - Read 8'h15 or 8'h0F → no `SirDack`.
  - Assert `rst` during a read of 8'h10 → next cycle `SirDack`=0, all Q = `INITVALUE`, `Upd`=0.
